data_memory_mc: RTL and testbench
=================================

DATA_MEMORY_MC -- requirements
Module: data_memory_mc

Interface
REQ-001 Parameter DATA_W, default 256: data bus width in bits; a multiple of 32.
REQ-002 Parameter DEPTH, default 512: number of DATA_W-bit entries; a power of two.
REQ-003 Parameter LATENCY, default 10: cycles from request acceptance to ack; at least 2.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 enable_i  input  1  request valid.
REQ-007 write_i  input  1  1 = write, 0 = read; sampled with enable_i.
REQ-008 addr_i  input  32  byte address.
REQ-009 data_i  input  DATA_W  write data.
REQ-010 ack_o  output  1  one-cycle completion pulse.
REQ-011 data_o  output  DATA_W  read data; valid while ack_o=1 after a read.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY and ACK.
REQ-013 In IDLE with enable_i=1, the block SHALL latch addr_i, data_i and write_i, load the counter with LATENCY-1, and enter BUSY.
REQ-014 In BUSY, the counter SHALL decrement by 1 each cycle.
REQ-015 In BUSY with counter=0, on the same edge the block SHALL either write the latched data to the entry, or load data_o from the entry, and then enter ACK.
REQ-016 In ACK, ack_o SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-017 For a request sampled at edge t, ack_o SHALL be high during the cycle after edge t+LATENCY.
REQ-018 The entry index SHALL be addr_i[log2(DATA_W/8) +: log2(DEPTH)].
REQ-019 Byte-offset bits SHALL be ignored.
REQ-020 Address bits above the index SHALL be ignored, so addresses wrap modulo DEPTH*DATA_W/8 bytes.
REQ-021 While the FSM is in BUSY or ACK, changes on enable_i, write_i, addr_i and data_i SHALL be ignored.
REQ-022 Dropping enable_i in BUSY SHALL NOT cancel the in-flight operation.
REQ-023 A request held high through ACK SHALL be accepted in the first IDLE cycle, giving a minimum spacing of LATENCY+2 cycles between back-to-back acks.
REQ-024 data_o SHALL keep its last value until the next read completes.
REQ-025 A write SHALL NOT change data_o.
REQ-026 ack_o SHALL be registered, and SHALL never be asserted in IDLE or BUSY.

Reset
REQ-027 When rst_i=1 at an edge, the block SHALL set the FSM to IDLE, the counter to 0, ack_o to 0, and data_o to 0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset during BUSY SHALL abort the operation: no memory write, no ack.
REQ-030 When rst_i and enable_i are both 1 at an edge, reset SHALL win and no request is accepted.

Structure
REQ-031 The FSM state encoding and the default values of DATA_W, DEPTH and LATENCY SHALL be defined in a shared package, dmem_pkg.
REQ-032 The storage array SHALL be a separate sub-module, dmem_array: one synchronous port with write enable, DATA_W wide and DEPTH deep.
REQ-033 The latency counter width SHALL be $clog2(LATENCY).

Verification
REQ-034 Write then read (defaults): write 0x400 (zero-extended) to addr 0x0; ack arrives 10 cycles after acceptance. Then read addr 0x0; ack arrives with data_o = 0x400.
REQ-035 Address alias: write pattern A to addr 0x20 and pattern B to addr 0x4020 (wraps, DEPTH=512, 32 B entries). Then read 0x20 -> B; read 0x3F -> B (offset ignored).
REQ-036 Input stability: after acceptance, toggle addr_i, data_i, write_i and drop enable_i during BUSY. The original operation completes; exactly one ack.
REQ-037 Mid-operation reset: assert rst_i 5 cycles into a write of 0xFF to addr 0x40. No ack; FSM returns to IDLE; a later read of 0x40 returns the prior contents.
REQ-038 Back-to-back: hold enable_i=1 for three reads. Acks are spaced 12 cycles apart (LATENCY=10); ack_o is never high for two consecutive cycles.
REQ-039 Parameter sweep: LATENCY=2, DATA_W=32, DEPTH=16. Write then read is correct, with ack at 2 cycles after acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the multi-cycle data memory: default
//                geometry/latency and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DMEM_DATA_W  = 256;
  localparam int DMEM_DEPTH   = 512;
  localparam int DMEM_LATENCY = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Single-port synchronous RAM, DATA_W wide and DEPTH deep.
//                Read data is registered (read-before-write on the port).
//                Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // One shared port: optional write plus a registered read of the same entry.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_memory_mc.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_mc
//  Description : Multi-cycle data memory. A request accepted in IDLE is held
//                in local registers while a counter runs down LATENCY-1..0;
//                on the edge where the counter is zero the access is made and
//                a one-cycle registered ack follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_mc
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dmem_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              ack_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata;
  logic              mem_we;
  logic              unused_addr;

  // Byte-offset bits and bits above the index do not select anything.
  assign unused_addr = ^{addr_i[31:OFF_W+IDX_W], addr_i[OFF_W-1:0]};

  // Write fires on the final BUSY edge; a reset on that edge suppresses it.
  assign mem_we = (state_q == ST_BUSY) && (cnt_q == '0) && write_q && !rst_i;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  // Controller: accept in IDLE, count down in BUSY, pulse ack in ACK.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (enable_i) begin
            idx_q   <= addr_i[OFF_W +: IDX_W];
            wdata_q <= data_i;
            write_q <= write_i;
            cnt_q   <= CNT_LOAD;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            // The array has been reading idx_q every cycle since acceptance,
            // so rdata already holds the addressed entry here.
            if (!write_q) begin
              data_q <= rdata;
            end
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_ACK: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_mc
//  Description : Self-checking bench for data_memory_mc (default geometry plus
//                a small LATENCY=2 / 32-bit / 16-entry instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_mc;

  localparam int L = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, wr, ack;
  logic [31:0]  addr;
  logic [255:0] din, dout;
  logic         en2, wr2, ack2;
  logic [31:0]  addr2, din2, dout2;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0, dbl = 0, exp_acks = 0, cyc = 0;
  logic prev_ack = 1'b0;

  logic [255:0] model [int];
  logic [255:0] last_rd;

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [255:0] d;
    logic [255:0] exp;
  } vec_t;

  data_memory_mc dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr),
    .addr_i(addr), .data_i(din), .ack_o(ack), .data_o(dout)
  );

  data_memory_mc #(.DATA_W(32), .DEPTH(16), .LATENCY(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en2), .write_i(wr2),
    .addr_i(addr2), .data_i(din2), .ack_o(ack2), .data_o(dout2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ack && prev_ack) dbl++;
    if (ack) ack_cnt++;
    prev_ack = ack;
  end

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32) % 512);
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One request on the default instance; checks latency, data and ack width.
  task automatic op(input logic w, input logic [31:0] a, input logic [255:0] d,
                    input bit scr, output logic [255:0] rd);
    int lat;
    bit seen;
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; din = d;
    @(posedge clk); #1;
    en = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      if (scr) begin
        en   = 1'($urandom_range(0, 1));
        wr   = 1'($urandom_range(0, 1));
        addr = $urandom;
        din  = {8{$urandom}};
      end
      @(posedge clk); #1;
      lat++;
      if (ack) seen = 1;
    end
    en = 1'b0;
    rd = dout;
    exp_acks++;
    chk_i("latency", lat, L);
    if (w) begin
      model[idx_of(a)] = d;
      chk("write_keeps_data_o", dout, last_rd);
    end else if (model.exists(idx_of(a))) begin
      chk("read_data", dout, model[idx_of(a)]);
      last_rd = model[idx_of(a)];
    end
    @(posedge clk); #1;
    chk_i("ack_one_cycle", int'(ack), 0);
  endtask

  task automatic op2(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp);
    int lat;
    @(negedge clk);
    en2 = 1'b1; wr2 = w; addr2 = a; din2 = d;
    @(posedge clk); #1;
    en2 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack2 && lat < 20);
    chk_i("small_latency", lat, 2);
    chk("small_data", 256'(dout2), 256'(exp));
    @(posedge clk); #1;
    chk_i("small_ack_one_cycle", int'(ack2), 0);
  endtask

  initial begin
    vec_t tbl[6];
    logic [255:0] pa, pb, pc, pd, rd;
    logic [31:0] ba[3];
    int tk[3];
    int n;

    pa = {8{32'hA5A5_0001}};
    pb = {8{32'h5A5A_0002}};
    pc = {8{32'h1234_5678}};
    pd = {8{32'hDEAD_BEEF}};

    tbl[0] = '{1'b1, 32'h0000_0000, 256'h400, 256'h0};
    tbl[1] = '{1'b0, 32'h0000_0000, 256'h0,   256'h400};
    tbl[2] = '{1'b1, 32'h0000_0020, pa,       256'h400};
    tbl[3] = '{1'b1, 32'h0000_4020, pb,       256'h400};
    tbl[4] = '{1'b0, 32'h0000_0020, 256'h0,   pb};
    tbl[5] = '{1'b0, 32'h0000_003F, 256'h0,   pb};

    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
    en2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_i("reset_ack", int'(ack), 0);
    chk("reset_data_o", dout, 256'h0);
    chk("reset_small_data_o", 256'(dout2), 256'h0);
    rst = 1'b0;
    last_rd = '0;

    // Directed write/read and address aliasing.
    for (int i = 0; i < 6; i++) begin
      op(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, rd);
      chk($sformatf("table_row%0d", i), rd, tbl[i].exp);
    end

    // Inputs scrambled while busy must not disturb the accepted request.
    op(1'b1, 32'h0000_0060, pc, 1'b1, rd);
    op(1'b0, 32'h0000_0060, 256'h0, 1'b0, rd);
    chk("scrambled_write", rd, pc);
    op(1'b0, 32'h0000_0020, 256'h0, 1'b1, rd);
    chk("scrambled_read", rd, pb);

    // Reset partway through a write aborts it.
    op(1'b1, 32'h0000_0040, pd, 1'b0, rd);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h40; din = 256'hFF;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    n = ack_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk_i("reset_abort_no_ack", ack_cnt, n);
    chk("reset_abort_data_o", dout, 256'h0);
    last_rd = '0;
    op(1'b0, 32'h0000_0040, 256'h0, 1'b0, rd);
    chk("reset_abort_kept_mem", rd, pd);

    // Back-to-back reads with enable held high.
    ba[0] = 32'h0; ba[1] = 32'h20; ba[2] = 32'h40;
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = ba[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!ack && n < 40);
      tk[k] = cyc;
      chk($sformatf("b2b_data%0d", k), dout, model[idx_of(ba[k])]);
      if (k < 2) addr = ba[k+1];
      else en = 1'b0;
    end
    exp_acks += 3;
    last_rd = model[idx_of(ba[2])];
    chk_i("b2b_spacing01", tk[1] - tk[0], L + 2);
    chk_i("b2b_spacing12", tk[2] - tk[1], L + 2);
    @(posedge clk); #1;

    // Randomized traffic over a handful of entries with random alias bits.
    for (int i = 0; i < 24; i++) begin
      logic        w;
      logic [31:0] a;
      int          ix;
      w  = 1'($urandom_range(0, 1));
      ix = int'($urandom_range(0, 7));
      a  = $urandom;
      a  = (a & ~32'h0000_3FE0) | 32'(ix * 32);
      if (!w && !model.exists(idx_of(a))) w = 1'b1;
      op(w, a, {8{$urandom}}, bit'($urandom_range(0, 1)), rd);
    end

    // Small instance: LATENCY=2, 32-bit words, 16 entries (64-byte wrap).
    op2(1'b1, 32'h08, 32'h5A5A_1234, 32'h0);
    op2(1'b1, 32'h4C, 32'hCAFE_0001, 32'h0);
    op2(1'b0, 32'h08, 32'h0,         32'h5A5A_1234);
    op2(1'b0, 32'h0E, 32'h0,         32'hCAFE_0001);
    op2(1'b1, 32'h08, 32'h1111_1111, 32'hCAFE_0001);
    op2(1'b0, 32'h48, 32'h0,         32'h1111_1111);

    repeat (3) @(posedge clk);
    #1;
    chk_i("total_acks", ack_cnt, exp_acks);
    chk_i("no_double_ack", dbl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
